// File: rtl/multi_channel_clock_divider.sv
// Multi-channel programmable clock divider with per-channel duty cycle,
// tick strobe, glitch-free config handoff and global phase sync.
module multi_channel_clock_divider #(
   parameter int CHANNELS       = 4,
   parameter int WORD_LENGTH    = 16,
   parameter int DEFAULT_PERIOD = 100,
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                   clock_i,
   input  logic                   reset_ni,
   input  logic [CHANNELS-1:0]    enable_i,
   input  logic                   sync_i,
   input  logic                   cfg_valid_i,
   output logic                   cfg_ready_o,
   input  logic [CH_W-1:0]        cfg_channel_i,
   input  logic [WORD_LENGTH-1:0] cfg_period_i,
   input  logic [WORD_LENGTH-1:0] cfg_high_i,
   output logic [CHANNELS-1:0]    clock_o,
   output logic [CHANNELS-1:0]    tick_o
);

   typedef logic [WORD_LENGTH-1:0] word_t;

   localparam word_t DEF_P = DEFAULT_PERIOD[WORD_LENGTH-1:0];
   localparam word_t DEF_H = DEF_P >> 1;

   logic [CHANNELS-1:0] pend_v;
   logic                accept;
   word_t               p_clamp;
   word_t               h_clamp;

   always_comb begin
      p_clamp = (cfg_period_i < word_t'(2)) ? word_t'(2) : cfg_period_i;
      h_clamp = (cfg_high_i > p_clamp) ? p_clamp : cfg_high_i;
   end

   // Unmapped channel numbers stay ready so their writes drain harmlessly.
   always_comb begin
      cfg_ready_o = 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
         if (cfg_channel_i == CH_W'(k)) begin
            cfg_ready_o = !pend_v[k];
         end
      end
   end

   assign accept = cfg_valid_i && cfg_ready_o;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      word_t act_p;
      word_t act_h;
      word_t pend_p;
      word_t pend_h;
      word_t cnt;
      word_t use_p;
      word_t use_h;
      word_t cnt_nx;
      logic  pv;
      logic  clk_q;
      logic  tick_q;
      logic  acc;
      logic  wrap;
      logic  load;

      always_comb begin
         acc    = accept && (cfg_channel_i == CH_W'(g));
         wrap   = sync_i || (cnt == act_p - word_t'(1));
         load   = pv && (wrap || !enable_i[g]);
         use_p  = load ? pend_p : act_p;
         use_h  = load ? pend_h : act_h;
         cnt_nx = wrap ? '0 : cnt + word_t'(1);
      end

      always_ff @(posedge clock_i or negedge reset_ni) begin
         if (!reset_ni) begin
            act_p  <= DEF_P;
            act_h  <= DEF_H;
            pend_p <= DEF_P;
            pend_h <= DEF_H;
            pv     <= 1'b0;
            cnt    <= DEF_P - word_t'(1);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            if (load) begin
               act_p <= pend_p;
               act_h <= pend_h;
            end
            if (acc) begin
               pend_p <= p_clamp;
               pend_h <= h_clamp;
               pv     <= 1'b1;
            end else if (load) begin
               pv <= 1'b0;
            end
            if (!enable_i[g]) begin
               cnt    <= use_p - word_t'(1);
               clk_q  <= 1'b0;
               tick_q <= 1'b0;
            end else begin
               cnt    <= cnt_nx;
               clk_q  <= (cnt_nx < use_h);
               tick_q <= (cnt_nx == use_p - word_t'(1));
            end
         end
      end

      assign pend_v[g]  = pv;
      assign clock_o[g] = clk_q;
      assign tick_o[g]  = tick_q;
   end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed bench for multi_channel_clock_divider: default timing, config
// handoff, clamping, sync alignment and asynchronous reset.
module tb_multi_channel_clock_divider;

   logic        clk;
   logic        rst_n;
   logic [3:0]  en;
   logic        sync;
   logic        cv;
   logic        cr;
   logic [1:0]  cch;
   logic [15:0] cp;
   logic [15:0] chh;
   logic [3:0]  clko;
   logic [3:0]  ticko;

   int checks;
   int failures;

   multi_channel_clock_divider #(
      .CHANNELS(4),
      .WORD_LENGTH(16),
      .DEFAULT_PERIOD(100)
   ) dut (
      .clock_i(clk),
      .reset_ni(rst_n),
      .enable_i(en),
      .sync_i(sync),
      .cfg_valid_i(cv),
      .cfg_ready_o(cr),
      .cfg_channel_i(cch),
      .cfg_period_i(cp),
      .cfg_high_i(chh),
      .clock_o(clko),
      .tick_o(ticko)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en    = '0;
      sync  = 1'b0;
      cv    = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   task automatic cfg(input logic [1:0] ch, input logic [15:0] p,
                      input logic [15:0] h);
      cv  = 1'b1;
      cch = ch;
      cp  = p;
      chh = h;
      cyc(1);
      cv  = 1'b0;
   endtask

   // Samples 100 cycles of channel 0 starting one cycle after enable.
   task automatic run_default(output int hi, output int nt,
                              output int tpos, output int other);
      hi = 0; nt = 0; tpos = -1; other = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         if (clko[0]) hi++;
         if (ticko[0]) begin
            nt++;
            tpos = i;
         end
         if (clko[3:1] != 3'b000 || ticko[3:1] != 3'b000) other++;
      end
   endtask

   initial begin
      int hi, nt, tpos, other, bad;
      logic [11:0] v0, v1, t0, t1;
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      en    = '0;
      sync  = 1'b0;
      cv    = 1'b0;
      cch   = '0;
      cp    = '0;
      chh   = '0;
      cyc(3);
      chk("reset_clk", {28'd0, clko}, 32'h0);
      chk("reset_tick", {28'd0, ticko}, 32'h0);
      chk("reset_ready", {31'd0, cr}, 32'h1);
      rst_n = 1'b1;

      // Default 100-cycle period, 50 high
      cyc(1);
      en = 4'b0001;
      run_default(hi, nt, tpos, other);
      chk("dflt_high", hi, 50);
      chk("dflt_ticks", nt, 1);
      chk("dflt_tickpos", tpos, 99);
      chk("dflt_others", other, 0);

      // Ch1 P=5 H=2 programmed while disabled
      do_reset();
      cyc(1);
      cch = 2'd1;
      chk("ch1_ready_pre", {31'd0, cr}, 32'h1);
      cfg(2'd1, 16'd5, 16'd2);
      chk("ch1_ready_pend", {31'd0, cr}, 32'h0);
      cyc(1);
      chk("ch1_ready_applied", {31'd0, cr}, 32'h1);
      en = 4'b0010;
      v0 = '0;
      t0 = '0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         v0[i] = clko[1];
         t0[i] = ticko[1];
      end
      chk("ch1_clk", {20'd0, v0}, 32'h063);
      chk("ch1_tick", {20'd0, t0}, 32'h210);

      // Ch0 reconfigured mid-period at count 30
      do_reset();
      cyc(1);
      en = 4'b0001;
      cyc(31);
      cv  = 1'b1;
      cch = 2'd0;
      cp  = 16'd4;
      chh = 16'd1;
      chk("ch0_ready_first", {31'd0, cr}, 32'h1);
      cyc(1);
      cp  = 16'd6;
      chh = 16'd3;
      bad = 0;
      for (int i = 31; i <= 99; i++) begin
         if (clko[0] !== (i < 50)) bad++;
         if (ticko[0] !== (i == 99)) bad++;
         if (cr !== 1'b0) bad++;
         if (i < 99) cyc(1);
      end
      chk("ch0_old_period", bad, 0);
      v0 = '0;
      t0 = '0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (i == 0) chk("ch0_ready_boundary", {31'd0, cr}, 32'h1);
         if (i == 1) begin
            chk("ch0_ready_second", {31'd0, cr}, 32'h0);
            cv = 1'b0;
         end
         v0[i] = clko[0];
         t0[i] = ticko[0];
      end
      chk("ch0_new_clk", {20'd0, v0}, 32'h071);
      chk("ch0_new_tick", {20'd0, t0}, 32'h208);

      // Clamping: ch2 P=0 H=9 -> 2/2, ch3 P=8 H=0
      do_reset();
      cyc(1);
      cfg(2'd2, 16'd0, 16'd9);
      cfg(2'd3, 16'd8, 16'd0);
      cyc(1);
      en = 4'b1100;
      v0 = '0; t0 = '0; v1 = '0; t1 = '0;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         v0[i] = clko[2];
         t0[i] = ticko[2];
         v1[i] = clko[3];
         t1[i] = ticko[3];
      end
      chk("clamp2_clk", {20'd0, v0}, 32'h0FF);
      chk("clamp2_tick", {20'd0, t0}, 32'h0AA);
      chk("clamp3_clk", {20'd0, v1}, 32'h000);
      chk("clamp3_tick", {20'd0, t1}, 32'h080);

      // Sync alignment: ch0 6/3, ch1 3/1
      do_reset();
      cyc(1);
      cfg(2'd0, 16'd6, 16'd3);
      cfg(2'd1, 16'd3, 16'd1);
      cyc(1);
      en = 4'b0001;
      cyc(2);
      en = 4'b0011;
      cyc(3);
      sync = 1'b1;
      cyc(1);
      sync = 1'b0;
      chk("sync_both_high", {30'd0, clko[1:0]}, 32'h3);
      v0 = '0; t0 = '0; v1 = '0; t1 = '0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) cyc(1);
         if (i == 11) cfg_start();
         v0[i] = clko[0];
         t0[i] = ticko[0];
         v1[i] = clko[1];
         t1[i] = ticko[1];
      end
      chk("sync_ch0_clk", {20'd0, v0}, 32'h1C7);
      chk("sync_ch0_tick", {20'd0, t0}, 32'h820);
      chk("sync_ch1_clk", {20'd0, v1}, 32'h249);
      chk("sync_ch1_tick", {20'd0, t1}, 32'h924);

      // Config accepted on a boundary waits; async reset drops it
      cyc(1);
      cv = 1'b0;
      chk("bnd_old_p_clk", {31'd0, clko[0]}, 32'h1);
      chk("bnd_pending", {31'd0, cr}, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_clk", {28'd0, clko}, 32'h0);
      chk("async_tick", {28'd0, ticko}, 32'h0);
      chk("async_ready", {31'd0, cr}, 32'h1);
      en = '0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      en = 4'b0001;
      run_default(hi, nt, tpos, other);
      chk("post_rst_high", hi, 50);
      chk("post_rst_tickpos", tpos, 99);
      chk("post_rst_ticks", nt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic cfg_start();
      cv  = 1'b1;
      cch = 2'd0;
      cp  = 16'd4;
      chh = 16'd1;
   endtask

endmodule

// File: doc/multi_channel_clock_divider.md
Name: multi_channel_clock_divider

Overview:
- Parametrised successor to the fixed single-output divider.
- Generates CHANNELS independent divided clocks from one system clock.
- Each channel has a runtime-programmable period and high time, so duty cycle is not fixed at 50%. Each channel also has a one-cycle tick strobe.
- Configuration updates are glitch-free, applied only at period boundaries. A global sync input phase-aligns all channels.
- Feeds peripheral timing (baud, PWM, display scan) in place of multiple fixed-ratio dividers.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- WORD_LENGTH, 16, width of period/high-time registers and per-channel counter.
- DEFAULT_PERIOD, 100, period in clock_i cycles loaded at reset (must be ≥2 and < 2^WORD_LENGTH).

Ports:
- clock_i  in  1  system clock; all logic on posedge.
- reset_ni  in  1  asynchronous, active-low reset.
- enable_i  in  CHANNELS  per-channel run enable.
- sync_i  in  1  restart all enabled channels at count 0 in phase.
- cfg_valid_i  in  1  configuration request valid.
- cfg_ready_o  out  1  configuration slot free for addressed channel.
- cfg_channel_i  in  CH_W  target channel, where CH_W = max(1, clog2(CHANNELS)).
- cfg_period_i  in  WORD_LENGTH  new period P in cycles.
- cfg_high_i  in  WORD_LENGTH  new high time H in cycles.
- clock_o  out  CHANNELS  divided clock per channel.
- tick_o  out  CHANNELS  one-cycle strobe in last cycle of each period.

Behaviour:

Reset:
- Reset is asynchronous, active-low, and takes effect immediately, including mid-operation.
- Per channel on reset: active P=DEFAULT_PERIOD, H=DEFAULT_PERIOD/2, counter=P-1, pending slot empty, clock_o=0, tick_o=0.
- cfg_ready_o=1 after reset.

Per-channel registers:
- Active P and H, a counter, and a single pending slot holding P, H and a valid flag.

Disabled (enable_i[k]=0):
- counter held at active P-1; clock_o[k]=0; tick_o[k]=0.
- A pending config, if any, is applied on that edge.

Enabled, each edge:
- count_next = 0 if counter==P-1, else counter+1.
- clock_o[k] <= (count_next < H).
- tick_o[k] <= (count_next == P-1).
- Outputs are flop-driven: clock_o equals (counter < H) and tick_o equals (counter == P-1) in every enabled cycle.

Enable rise:
- The first enabled edge wraps the counter to 0, so clock_o is high one cycle after enable_i is sampled high (if H>0).
- No partial first period.

Period boundary:
- The edge where the counter goes P-1 → 0, or any sync edge.
- If the pending slot is valid at a boundary: load P/H, clear the valid flag, and compute that edge's outputs from the NEW P/H.
- The period in progress always completes with the old values.

Configuration handshake:
- cfg_ready_o = !pending_valid[cfg_channel_i] (combinational).
- Transfer occurs on an edge where cfg_valid_i && cfg_ready_o.
- cfg_channel_i ≥ CHANNELS: ready=1 and the transfer is accepted and discarded.
- A config accepted on the same edge as a boundary is not applied on that edge; it waits for the next boundary.
- On a disabled channel, it applies on the following edge.

Clamping, applied at acceptance:
- P<2 → P=2.
- H>P → H=P, giving a constant-high clock_o while enabled.
- H=0 → clock_o constant low; tick_o still pulses every P cycles.

sync_i:
- On that edge, every enabled channel is forced to counter 0, with pending applied.
- clock_o <= (0 < H); tick_o <= (P-1 == 0), which is always 0.
- Disabled channels are unaffected.
- sync_i takes priority over the natural wrap.

Arithmetic:
- Unsigned comparisons throughout.
- The counter never exceeds P-1, so no wrap at 2^WORD_LENGTH.
- Channels are fully independent except for sync_i and the shared config port.

Test Plan:
- Reset, enable_i=0001, no config → clock_o[0] high 50 / low 50 cycles repeating. tick_o[0] pulses once per 100 cycles, coincident with the last low cycle. Channels 1-3 stay 0.
- Config ch1 P=5 H=2 while disabled, then enable_i[1]=1 → starting one cycle after enable, clock_o[1] repeats 1,1,0,0,0; tick_o[1] high on each 5th cycle.
- Ch0 running at default: at counter=30, config P=4 H=1 → remaining 70 cycles unchanged, then 1,0,0,0 repeating. A second config to ch0 before that boundary sees cfg_ready_o=0 until the boundary edge.
- Config ch2 P=0 H=9 → clamped P=2 H=2. Enabled: clock_o[2] constant 1, tick_o[2] every 2nd cycle. Config ch3 P=8 H=0 → clock_o[3] constant 0, tick every 8 cycles.
- Ch0 P=6 H=3 and ch1 P=3 H=1, enabled 2 cycles apart, then pulse sync_i → next cycle both counters 0 and both clock_o high. Rising edges coincide every 6 cycles thereafter.
- Assert reset_ni low mid-period with clock_o[0]=1 → clock_o and tick_o go 0 without waiting for a clock edge. After release, a re-enabled channel shows default 50/50 timing and pending configs are lost.
